bnn_ctrl: RTL and testbench
===========================

# bnn_ctrl

Sequencer and parameter store for the tiny binary neural network layer. It shifts the serial parameter stream into a weight/threshold bank and assembles the 8-bit input vector from two 4-bit nibble transfers. It then evaluates the 8 output neurons one per cycle on a shared XNOR-popcount-compare unit and presents the registered 8-bit result. It sits between the pin-level input decode (setup / param_in / nibble bank select) and the `uo_out` byte.

## Interface
- `N_IN`, 8: input vector width (bits).
- `N_OUT`, 8: neuron count, equal to the output width.
- `THR_W`, 4: threshold width per neuron.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle pulse that begins a parameter load.
- `cfg_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_bit`  in  1  serial parameter bit.
- `cfg_ready`  out  1  high while in LOAD.
- `cfg_done`  out  1  high once a full load completes; sticky until the next `cfg_start`.
- `x_valid`  in  1  nibble transfer strobe.
- `x_hi`  in  1  1 = upper nibble, 0 = lower nibble.
- `x_nib`  in  4  nibble data.
- `busy`  out  1  high in RUN.
- `y`  out  8  registered neuron outputs.
- `y_valid`  out  1  one-cycle pulse when `y` updates.

## Operation
- States:
  - UNCFG: after reset.
  - LOAD
  - READY
  - HALF: lower nibble held.
  - RUN
- Parameter image: P = N_OUT*(N_IN+THR_W) = 96 bits, held in a shift register.
  - Each accepted bit enters at bit 0 and everything shifts left, so the first bit ends at bit 95.
  - Neuron j uses bits [j*12 +: 12]: [11:4] are the weights w_j and [3:0] are the threshold thr_j.
- `cfg_start` is honoured in any state. It moves to LOAD, clears the bit counter and `cfg_done`, and aborts any RUN without a `y_valid` pulse; `y` keeps its old value.
- If `cfg_start` and `cfg_valid` are high in the same cycle, start wins and the bit is discarded.
- In LOAD, each `cfg_valid` cycle shifts one bit in; gaps are allowed. The 96th bit moves to READY and sets `cfg_done`.
- UNCFG and LOAD: `x_valid` is ignored.
- READY:
  - A lower nibble is stored and the FSM moves to HALF.
  - An upper nibble is ignored.
- HALF:
  - A lower nibble overwrites the stored one.
  - An upper nibble forms x = {hi, lo}, clears the neuron index and moves to RUN.
- RUN:
  - Each cycle, bit idx of the work register gets (popcount(~(x ^ w_idx)) >= thr_idx), then idx increments.
  - The popcount is 0..8, compared unsigned against a 4-bit threshold: thr=0 always gives 1, thr>8 always gives 0.
  - `x_valid` is ignored in RUN.
- At idx=7: `y` gets the completed vector, `y_valid` is set, and the FSM returns to READY.

## Timing
- Reset values: state UNCFG, all registers 0, and `y`, `y_valid`, `busy`, `cfg_ready`, `cfg_done` all 0.
- Latency: `y_valid` is high in the cycle following the 8th rising edge after the edge that accepted the upper nibble, for exactly one cycle.
- `busy` is high for those 8 cycles.
- A new lower nibble can be accepted on the edge right after `y_valid` is set (READY).
- `cfg_ready` and `busy` are decoded directly from registered state and are glitch-free.
- Reset asserted mid-LOAD or mid-RUN returns immediately to UNCFG; a full reload is required.

## Structure
- Shared package `bnn_pkg` holds:
  - `N_IN`, `N_OUT`, `THR_W`
  - `NEUR_W` = N_IN+THR_W, and `P_BITS`
  - the state enum (UNCFG, LOAD, READY, HALF, RUN)
- One sub-module, `bnn_neuron`: combinational XNOR, popcount and >= compare.
  - Inputs: x[7:0], w[7:0], thr[3:0].
  - Output: 1-bit fire.
  - Instantiated once and fed by an index mux.

## Test plan
- Reset, then send nibbles lo 0x5 / hi 0xA without any config -> no `y_valid`, `y`=0x00, `cfg_done`=0.
- Load 96 bits with every neuron w=0xFF, thr=8; send x=0xFF -> `y`=0xFF with `y_valid` 8 edges after the hi nibble, `busy` high for 8 cycles. Then send x=0x7F -> `y`=0x00.
- Load w_j=0x00, thr_j=j+1; send x=0x0F (4 XNOR matches) -> `y`=0x0F. Reload with all thr=0 -> `y`=0xFF; with all thr=15 -> `y`=0x00.
- Nibble ordering: hi 0x9 in READY is ignored; lo 0x3, lo 0xC, hi 0x5 gives x=0x5C. With w=0x5C, thr=8 everywhere -> `y`=0xFF.
- Pulse `cfg_start` at RUN cycle 4 -> no `y_valid`, `y` keeps its previous value, `cfg_ready`=1. Reload with `cfg_valid` gaps plus a same-cycle `cfg_start`+`cfg_valid` -> bit discarded, `cfg_done` after exactly 96 accepted bits.
- Assert `rst_n` low after 50 config bits -> all outputs 0 asynchronously, state UNCFG, and a subsequent x transfer produces no `y_valid`.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared sizes and FSM state type for the binary neural network layer controller.
package bnn_pkg;

    localparam int unsigned N_IN   = 8;
    localparam int unsigned N_OUT  = 8;
    localparam int unsigned THR_W  = 4;
    localparam int unsigned NEUR_W = N_IN + THR_W;
    localparam int unsigned P_BITS = N_OUT * NEUR_W;
    localparam int unsigned CNT_W  = $clog2(P_BITS);
    localparam int unsigned IDX_W  = $clog2(N_OUT);
    localparam int unsigned PC_W   = $clog2(N_IN + 1);

    typedef enum logic [2:0] {
        StUncfg,
        StLoad,
        StReady,
        StHalf,
        StRun
    } state_t;

endpackage

// File: rtl/bnn_neuron.sv
// One binary neuron: XNOR of input and weights, popcount, unsigned compare with threshold.
module bnn_neuron
    import bnn_pkg::*;
(
    input  logic [N_IN-1:0]  x,
    input  logic [N_IN-1:0]  w,
    input  logic [THR_W-1:0] thr,
    output logic             fire
);

    logic [N_IN-1:0] match;
    logic [PC_W-1:0] pc;

    assign match = ~(x ^ w);

    always_comb begin
        pc = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            pc = pc + PC_W'(match[i]);
        end
    end

    // Both sides zero-extended so a threshold above N_IN can never fire.
    assign fire = (32'(pc) >= 32'(thr));

endmodule

// File: rtl/bnn_ctrl.sv
// Parameter shift-in, nibble assembly and one-neuron-per-cycle evaluation sequencer.
module bnn_ctrl
    import bnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic             x_valid,
    input  logic             x_hi,
    input  logic [3:0]       x_nib,
    output logic             busy,
    output logic [N_OUT-1:0] y,
    output logic             y_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

    state_t             state_q;
    logic [P_BITS-1:0]  param_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         lo_q;
    logic [N_IN-1:0]    x_q;
    logic [IDX_W-1:0]   idx_q;
    logic [N_OUT-1:0]   work_q;
    logic [N_OUT-1:0]   y_q;
    logic               y_valid_q;
    logic               cfg_done_q;

    logic [NEUR_W-1:0]  neur_sel;
    logic               fire;
    logic [N_OUT-1:0]   work_nxt;

    // Index mux feeding the single shared neuron.
    always_comb begin
        neur_sel = param_q[int'(idx_q) * int'(NEUR_W) +: NEUR_W];
    end

    bnn_neuron u_neuron (
        .x    (x_q),
        .w    (neur_sel[NEUR_W-1:THR_W]),
        .thr  (neur_sel[THR_W-1:0]),
        .fire (fire)
    );

    always_comb begin
        work_nxt        = work_q;
        work_nxt[idx_q] = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StUncfg;
            param_q    <= '0;
            cnt_q      <= '0;
            lo_q       <= '0;
            x_q        <= '0;
            idx_q      <= '0;
            work_q     <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (cfg_start) begin
                // Start wins over everything, including a same-cycle cfg_valid bit.
                state_q    <= StLoad;
                cnt_q      <= '0;
                cfg_done_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StUncfg: ;
                    StLoad: begin
                        if (cfg_valid) begin
                            param_q <= {param_q[P_BITS-2:0], cfg_bit};
                            cnt_q   <= cnt_q + 1'b1;
                            if (cnt_q == CNT_LAST) begin
                                state_q    <= StReady;
                                cfg_done_q <= 1'b1;
                            end
                        end
                    end
                    StReady: begin
                        if (x_valid && !x_hi) begin
                            lo_q    <= x_nib;
                            state_q <= StHalf;
                        end
                    end
                    StHalf: begin
                        if (x_valid) begin
                            if (x_hi) begin
                                x_q     <= {x_nib, lo_q};
                                idx_q   <= '0;
                                state_q <= StRun;
                            end else begin
                                lo_q <= x_nib;
                            end
                        end
                    end
                    StRun: begin
                        work_q <= work_nxt;
                        idx_q  <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            y_q       <= work_nxt;
                            y_valid_q <= 1'b1;
                            state_q   <= StReady;
                        end
                    end
                    default: state_q <= StUncfg;
                endcase
            end
        end
    end

    assign cfg_ready = (state_q == StLoad);
    assign busy      = (state_q == StRun);
    assign cfg_done  = cfg_done_q;
    assign y         = y_q;
    assign y_valid   = y_valid_q;

endmodule

// File: tb/tb_bnn_ctrl.sv
// Directed self-checking bench for bnn_ctrl with hand-computed expected outputs.
module tb_bnn_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_ready;
    logic       cfg_done;
    logic       x_valid;
    logic       x_hi;
    logic [3:0] x_nib;
    logic       busy;
    logic [7:0] y;
    logic       y_valid;

    int n_cmp;
    int n_err;

    bnn_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .x_valid   (x_valid),
        .x_hi      (x_hi),
        .x_nib     (x_nib),
        .busy      (busy),
        .y         (y),
        .y_valid   (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Neuron j occupies img[j*12 +: 12] = {w, thr}; bit 95 is sent first.
    function automatic logic [95:0] mk_img(input logic [7:0] w, input logic [3:0] thr_base,
                                           input logic thr_inc);
        logic [95:0] img;
        img = '0;
        for (int j = 0; j < 8; j++) begin
            img[j*12 +: 12] = {w, thr_base + (thr_inc ? 4'(j) : 4'd0)};
        end
        return img;
    endfunction

    task automatic pulse_start(input logic with_valid);
        cfg_start = 1'b1;
        cfg_valid = with_valid;
        cfg_bit   = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic shift_bits(input logic [95:0] img, input int first, input int nbits,
                              input int gap_every);
        for (int i = first; i < first + nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = img[95-i];
            step();
            cfg_valid = 1'b0;
            if (gap_every != 0 && (i % gap_every) == 0) step();
        end
    endtask

    task automatic load(input string tag, input logic [95:0] img);
        pulse_start(1'b0);
        check({tag, "_ready_in_load"}, cfg_ready, 1);
        check({tag, "_done_cleared"}, cfg_done, 0);
        shift_bits(img, 0, 96, 0);
        check({tag, "_done"}, cfg_done, 1);
        check({tag, "_ready_after"}, cfg_ready, 0);
    endtask

    task automatic send_nib(input logic hi, input logic [3:0] nib);
        x_valid = 1'b1;
        x_hi    = hi;
        x_nib   = nib;
        step();
        x_valid = 1'b0;
    endtask

    task automatic run_x(input string tag, input logic [7:0] x, input logic [7:0] exp_y);
        int  n;
        int  bc;
        bit  got;
        send_nib(1'b0, x[3:0]);
        check({tag, "_yv_pulse_end"}, y_valid, 0);
        send_nib(1'b1, x[7:4]);
        n   = 0;
        bc  = 0;
        got = 0;
        while (n < 20 && !got) begin
            if (busy) bc++;
            step();
            n++;
            if (y_valid) got = 1;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy_cycles"}, bc, 8);
        check({tag, "_busy_at_yv"}, busy, 0);
        check({tag, "_y"}, y, exp_y);
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        int yv;
        int bz;
        yv = 0;
        bz = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (y_valid) yv++;
            if (busy) bz++;
        end
        check({tag, "_no_yvalid"}, yv, 0);
        check({tag, "_no_busy"}, bz, 0);
    endtask

    logic [95:0] img_ff8;
    logic [95:0] img_5c8;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        x_valid   = 1'b0;
        x_hi      = 1'b0;
        x_nib     = 4'h0;
        img_ff8   = mk_img(8'hFF, 4'd8, 1'b0);
        img_5c8   = mk_img(8'h5C, 4'd8, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_cfg_done", cfg_done, 0);

        // Unconfigured: nibbles are ignored.
        send_nib(1'b0, 4'h5);
        send_nib(1'b1, 4'hA);
        watch_idle("uncfg", 12);
        check("uncfg_y", y, 0);
        check("uncfg_cfg_done", cfg_done, 0);

        load("ld_ff8", img_ff8);
        run_x("ff8_xff", 8'hFF, 8'hFF);
        run_x("ff8_x7f", 8'h7F, 8'h00);

        load("ld_thr_inc", mk_img(8'h00, 4'd1, 1'b1));
        run_x("inc_x0f", 8'h0F, 8'h0F);
        load("ld_thr0", mk_img(8'h00, 4'd0, 1'b0));
        run_x("thr0_x0f", 8'h0F, 8'hFF);
        load("ld_thr15", mk_img(8'h00, 4'd15, 1'b0));
        run_x("thr15_x0f", 8'h0F, 8'h00);

        // Nibble ordering: a stray hi in READY is dropped, a second lo overwrites the first.
        load("ld_5c", img_5c8);
        send_nib(1'b1, 4'h9);
        watch_idle("hi_in_ready", 10);
        send_nib(1'b0, 4'h3);
        run_x("order_5c", 8'h5C, 8'hFF);

        // Abort at RUN cycle 4 with a same-cycle start+valid whose bit must be dropped.
        send_nib(1'b0, 4'h0);
        send_nib(1'b1, 4'h0);
        for (int i = 0; i < 4; i++) step();
        check("abort_busy_before", busy, 1);
        pulse_start(1'b1);
        check("abort_busy", busy, 0);
        check("abort_cfg_ready", cfg_ready, 1);
        check("abort_cfg_done", cfg_done, 0);
        watch_idle("abort", 10);
        check("abort_y_kept", y, 8'hFF);
        shift_bits(img_ff8, 0, 95, 3);
        check("gap_done_at_95", cfg_done, 0);
        shift_bits(img_ff8, 95, 1, 0);
        check("gap_done_at_96", cfg_done, 1);
        run_x("gap_xff", 8'hFF, 8'hFF);

        // Asynchronous reset in the middle of a load.
        pulse_start(1'b0);
        shift_bits(img_ff8, 0, 50, 0);
        check("mid_load_ready", cfg_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_y", y, 0);
        check("arst_cfg_ready", cfg_ready, 0);
        check("arst_cfg_done", cfg_done, 0);
        check("arst_busy", busy, 0);
        check("arst_y_valid", y_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        send_nib(1'b0, 4'hF);
        send_nib(1'b1, 4'hF);
        watch_idle("after_arst", 12);
        check("after_arst_y", y, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
